// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit RISC core: fetch/decode/execute/memory/writeback
// sequencing over a shared req/ack memory port, with a sticky memory-timeout fault.
module multicycle_control #(
  parameter int unsigned          OPC_W       = 4,
  parameter logic [OPC_W-1:0]     OP_LW       = OPC_W'(0),
  parameter logic [OPC_W-1:0]     OP_SW       = OPC_W'(1),
  parameter logic [OPC_W-1:0]     OP_BEQ      = OPC_W'(11),
  parameter logic [OPC_W-1:0]     OP_BNE      = OPC_W'(12),
  parameter logic [OPC_W-1:0]     OP_J        = OPC_W'(13),
  parameter int unsigned          MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_r,
  output logic             mem_w,
  output logic             i_or_d,
  output logic             ir_w,
  output logic             pc_w,
  output logic [1:0]       pc_src,
  output logic             reg_dst,
  output logic             reg_w,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic             fault,
  output logic [3:0]       state
);

  localparam int unsigned    CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_fault;
  logic             w_is_wait;
  logic             w_timeout;

  // State, timeout counter and sticky fault registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_state_nxt == S_FAULT) r_fault <= 1'b1;
    end
  end

  assign state = r_state;
  assign fault = r_fault;

  // Next state and Moore-decoded controls
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mem_r       = 1'b0;
    mem_w       = 1'b0;
    i_or_d      = 1'b0;
    ir_w        = 1'b0;
    pc_w        = 1'b0;
    pc_src      = 2'b00;
    reg_dst     = 1'b0;
    reg_w       = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    instr_done  = 1'b0;
    w_is_wait   = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    w_timeout   = (r_cnt == CNT_MAX) && !mem_ack;

    case (r_state)
      S_RST: w_state_nxt = S_FETCH;
      S_FETCH: begin
        mem_r     = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        ir_w      = mem_ack;
        pc_w      = mem_ack;
        if (mem_ack)        w_state_nxt = S_DECODE;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        if (opcode == OP_LW || opcode == OP_SW)        w_state_nxt = S_MEM_ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE) w_state_nxt = S_BRANCH;
        else if (opcode == OP_J)                       w_state_nxt = S_JUMP;
        else                                           w_state_nxt = S_EXEC;
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_op      = 2'b10;
        w_state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_r  = 1'b1;
        i_or_d = 1'b1;
        if (mem_ack)        w_state_nxt = S_MEM_WB;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_MEM_WB: begin
        reg_w       = 1'b1;
        mem_to_reg  = 1'b1;
        instr_done  = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_MEM_WR: begin
        mem_w      = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ack;
        if (mem_ack)        w_state_nxt = S_FETCH;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        w_state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_w       = 1'b1;
        reg_dst     = 1'b1;
        instr_done  = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = 2'b01;
        pc_src      = 2'b01;
        pc_w        = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
        instr_done  = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_w        = 1'b1;
        pc_src      = 2'b10;
        instr_done  = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_FAULT;
    endcase

    // Any state change (wait-state entry, or leaving on ack/timeout) restarts the count
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (w_is_wait && !mem_ack && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and full control-vector checks
// against hand-computed constants.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_r, mem_w, i_or_d, ir_w, pc_w;
  logic [1:0] pc_src;
  logic       reg_dst, reg_w, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       instr_done, fault;
  logic [3:0] state;
  logic [16:0] w_outs;

  int n_checks = 0;
  int n_errors = 0;

  // Packed as: mem_r mem_w i_or_d ir_w pc_w pc_src reg_dst reg_w mem_to_reg alu_src_a alu_src_b alu_op instr_done fault
  localparam logic [16:0] O_ZERO  = 17'b0_0_0_0_0_00_0_0_0_0_00_00_0_0;
  localparam logic [16:0] O_F0    = 17'b1_0_0_0_0_00_0_0_0_0_01_10_0_0;
  localparam logic [16:0] O_F1    = 17'b1_0_0_1_1_00_0_0_0_0_01_10_0_0;
  localparam logic [16:0] O_DEC   = 17'b0_0_0_0_0_00_0_0_0_0_10_10_0_0;
  localparam logic [16:0] O_MA    = 17'b0_0_0_0_0_00_0_0_0_1_10_10_0_0;
  localparam logic [16:0] O_MRD   = 17'b1_0_1_0_0_00_0_0_0_0_00_00_0_0;
  localparam logic [16:0] O_MWB   = 17'b0_0_0_0_0_00_0_1_1_0_00_00_1_0;
  localparam logic [16:0] O_MWR0  = 17'b0_1_1_0_0_00_0_0_0_0_00_00_0_0;
  localparam logic [16:0] O_MWR1  = 17'b0_1_1_0_0_00_0_0_0_0_00_00_1_0;
  localparam logic [16:0] O_EXEC  = 17'b0_0_0_0_0_00_0_0_0_1_00_00_0_0;
  localparam logic [16:0] O_AWB   = 17'b0_0_0_0_0_00_1_1_0_0_00_00_1_0;
  localparam logic [16:0] O_BR_T  = 17'b0_0_0_0_1_01_0_0_0_1_00_01_1_0;
  localparam logic [16:0] O_BR_N  = 17'b0_0_0_0_0_01_0_0_0_1_00_01_1_0;
  localparam logic [16:0] O_JMP   = 17'b0_0_0_0_1_10_0_0_0_0_00_00_1_0;
  localparam logic [16:0] O_FAULT = 17'b0_0_0_0_0_00_0_0_0_0_00_00_0_1;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_r(mem_r), .mem_w(mem_w), .i_or_d(i_or_d), .ir_w(ir_w), .pc_w(pc_w),
    .pc_src(pc_src), .reg_dst(reg_dst), .reg_w(reg_w), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .fault(fault), .state(state)
  );

  assign w_outs = {mem_r, mem_w, i_or_d, ir_w, pc_w, pc_src, reg_dst, reg_w, mem_to_reg,
                   alu_src_a, alu_src_b, alu_op, instr_done, fault};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle's state and controls (inputs already applied), then advance a clock
  task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] o);
    #2;
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_outs"}, 32'(w_outs), 32'(o));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc("rst_hold", 4'd0, O_ZERO);
    rst_n = 1'b1;
    cyc("rst_rel", 4'd0, O_ZERO);
    cyc("fetch_noack", 4'd1, O_F0);

    // LW, zero-wait
    opcode = 4'd0; mem_ack = 1'b1; cyc("lw_fetch", 4'd1, O_F1);
    mem_ack = 1'b0;                cyc("lw_dec", 4'd2, O_DEC);
                                   cyc("lw_addr", 4'd3, O_MA);
    mem_ack = 1'b1;                cyc("lw_rd", 4'd4, O_MRD);
    mem_ack = 1'b0;                cyc("lw_wb", 4'd5, O_MWB);

    // R-type
    opcode = 4'd5; mem_ack = 1'b1; cyc("r_fetch", 4'd1, O_F1);
    mem_ack = 1'b0;                cyc("r_dec", 4'd2, O_DEC);
                                   cyc("r_exec", 4'd7, O_EXEC);
                                   cyc("r_wb", 4'd8, O_AWB);

    // SW with ack delayed two cycles
    opcode = 4'd1; mem_ack = 1'b1; cyc("sw_fetch", 4'd1, O_F1);
    mem_ack = 1'b0;                cyc("sw_dec", 4'd2, O_DEC);
                                   cyc("sw_addr", 4'd3, O_MA);
                                   cyc("sw_wait1", 4'd6, O_MWR0);
                                   cyc("sw_wait2", 4'd6, O_MWR0);
    mem_ack = 1'b1;                cyc("sw_ack", 4'd6, O_MWR1);

    // BEQ taken / not taken, BNE taken
    opcode = 4'd11;                cyc("beq1_fetch", 4'd1, O_F1);
    mem_ack = 1'b0;                cyc("beq1_dec", 4'd2, O_DEC);
    zero = 1'b1;                   cyc("beq1_br", 4'd9, O_BR_T);
    mem_ack = 1'b1;                cyc("beq0_fetch", 4'd1, O_F1);
    mem_ack = 1'b0;                cyc("beq0_dec", 4'd2, O_DEC);
    zero = 1'b0;                   cyc("beq0_br", 4'd9, O_BR_N);
    opcode = 4'd12; mem_ack = 1'b1; cyc("bne0_fetch", 4'd1, O_F1);
    mem_ack = 1'b0;                cyc("bne0_dec", 4'd2, O_DEC);
                                   cyc("bne0_br", 4'd9, O_BR_T);

    // Jump
    opcode = 4'd13; mem_ack = 1'b1; cyc("j_fetch", 4'd1, O_F1);
    mem_ack = 1'b0;                cyc("j_dec", 4'd2, O_DEC);
                                   cyc("j_jump", 4'd10, O_JMP);

    // Ack on the 16th FETCH cycle wins over the timeout
    opcode = 4'd5;
    for (int i = 0; i < 15; i++) cyc("late_wait", 4'd1, O_F0);
    mem_ack = 1'b1;                cyc("late_ack", 4'd1, O_F1);
    mem_ack = 1'b0;                cyc("late_dec", 4'd2, O_DEC);
                                   cyc("late_exec", 4'd7, O_EXEC);
                                   cyc("late_wb", 4'd8, O_AWB);

    // No ack for 16 FETCH cycles -> FAULT, which is absorbing
    for (int i = 0; i < 16; i++) cyc("to_wait", 4'd1, O_F0);
                                   cyc("to_fault", 4'd11, O_FAULT);
    mem_ack = 1'b1;                cyc("to_absorb", 4'd11, O_FAULT);

    // Reset clears FAULT
    rst_n = 1'b0; mem_ack = 1'b0;  cyc("frst_pre", 4'd11, O_FAULT);
    rst_n = 1'b1;                  cyc("frst_post", 4'd0, O_ZERO);

    // Reset in the middle of a load read
    opcode = 4'd0; mem_ack = 1'b1; cyc("mr_fetch", 4'd1, O_F1);
    mem_ack = 1'b0;                cyc("mr_dec", 4'd2, O_DEC);
                                   cyc("mr_addr", 4'd3, O_MA);
                                   cyc("mr_rd", 4'd4, O_MRD);
    rst_n = 1'b0;                  cyc("mr_rd_rst", 4'd4, O_MRD);
    rst_n = 1'b1;                  cyc("mr_post", 4'd0, O_ZERO);
                                   cyc("mr_refetch", 4'd1, O_F0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
